exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute-stage pipeline register and control. Sits between decode and the team's combinational ALU.
- Latches decoded operands from decode using a valid/allowin handshake and drives the ALU inputs from those registers.
- Turns the ALU branch outcome into a single flush pulse, issues the data-SRAM request and passes results to the memory stage.

Parameters:
- PC_RESET, 32'h1bfffffc: reset value of the held PC register.
- ALU_OP_W, 5: width of the ALU opcode.

Ports:
- clk  in  1: clock.
- resetn  in  1: asynchronous reset, active-low.
- ds_to_es_valid  in  1: decode holds a valid instruction.
- ds_pc  in  32: instruction PC.
- ds_alu_op  in  ALU_OP_W: ALU opcode.
- ds_src1, ds_src2  in  32 each: selected ALU operands.
- ds_rf_src1, ds_rf_src2  in  32 each: raw register values used for branch compare.
- ds_dest  in  5: destination register.
- ds_gr_we  in  1: register write enable.
- ds_mem_we  in  1: store.
- ds_res_from_mem  in  1: load.
- ds_st_data  in  32: store data.
- es_allowin  out  1: execute stage can accept.
- exe_pc, src1, src2, alu_rf_src1, alu_rf_src2  out  32 each: ALU inputs.
- alu_op  out  ALU_OP_W: ALU opcode.
- exe_alu_result  in  32: from ALU.
- exe_br_taken  in  1: from ALU.
- exe_br_target  in  32: from ALU.
- br_flush  out  1: redirect fetch, kill decode.
- br_target  out  32: redirect PC.
- ms_allowin  in  1: memory stage can accept.
- es_to_ms_valid  out  1: valid toward memory stage.
- es_pc, es_result  out  32 each: PC and ALU result to memory stage.
- es_dest  out  5: destination to memory stage.
- es_gr_we, es_res_from_mem  out  1 each: controls to memory stage.
- data_sram_en  out  1: data-SRAM request.
- data_sram_we  out  4: byte write enables.
- data_sram_addr, data_sram_wdata  out  32 each: address and write data.

Behaviour:
- Registers: es_valid, every ds_* field, br_done.
- Reset (resetn low, asynchronous):
  - es_valid=0, br_done=0, es_pc/exe_pc=PC_RESET.
  - All other held fields 0, so every output derived from them reads 0.
  - Outputs: es_allowin=1, br_flush=0, es_to_ms_valid=0, data_sram_en=0, data_sram_we=0.
- Reset mid-operation discards the held instruction; no flush or SRAM request follows.
- Ready-go is always 1 (single-cycle stage).
- Handshake:
  - es_allowin = !es_valid || ms_allowin.
  - es_to_ms_valid = es_valid.
- Load, on the clock edge when es_allowin:
  - es_valid <= ds_to_es_valid && !br_flush.
  - Fields load only when ds_to_es_valid && es_allowin; otherwise they hold.
  - br_done clears on any load.
- Simultaneous flush and incoming instruction: the incoming wrong-path instruction is dropped (es_valid becomes 0) while the branch itself moves to memory stage.
- Flush:
  - br_flush = es_valid && exe_br_taken && !br_done, combinational.
  - br_target = exe_br_target.
  - br_done sets when br_flush && !es_allowin, so a stalled branch flushes exactly once.
- ALU inputs are driven directly from the held registers; exe_pc = held PC.
- es_result = exe_alu_result.
- Memory request:
  - data_sram_en = es_valid && ms_allowin && (mem_we || res_from_mem), issued only on the cycle the instruction leaves.
  - data_sram_we = {4{mem_we && data_sram_en}}.
  - data_sram_addr = exe_alu_result; data_sram_wdata = held st_data.
- Stall (ms_allowin=0): all held fields and ALU inputs stay stable; data_sram_en=0.
- Back-to-back: a new instruction is accepted in the same cycle the old one leaves, with no bubble.

Optional Feature:
- Macro: EXE_FWD_EN.
- Defined: adds outputs es_fwd_valid (1), es_fwd_dest (5), es_fwd_data (32) and es_load_block (1).
  - es_fwd_valid = es_valid && gr_we && dest!=0.
  - es_fwd_data = exe_alu_result.
  - es_load_block = es_fwd_valid && res_from_mem, used by decode to stall on load-use.
- Undefined: these ports and their logic do not exist; decode relies on interlock only.

Test Plan:
- Reset check: hold resetn=0 → es_allowin=1, es_to_ms_valid=0, br_flush=0, exe_pc=PC_RESET. Release, send add (op 0, src1=3, src2=4, ALU result 7) → next cycle es_to_ms_valid=1, es_result=7.
- Branch with wrong-path drop: beq (op 11) with equal rf_src values, pc=0x1c000000, ALU target 0x1c000010, ds_to_es_valid=1 on the same cycle → br_flush=1 for one cycle, br_target=0x1c000010, following es_valid=0.
- Stalled branch: ms_allowin=0 for 3 cycles while the taken branch is held → br_flush high only in the first cycle; ALU inputs stable throughout; branch leaves when ms_allowin=1.
- Store: mem_we=1, ALU addr 0x100, st_data=0xdeadbeef, ms_allowin=1 → data_sram_en=1, we=4'hf, addr=0x100, wdata=0xdeadbeef for exactly one cycle. Repeat with ms_allowin low first → no request until it rises.
- Async reset mid-stall: assert resetn=0 between clock edges while valid and stalled → outputs return to reset values immediately, with no SRAM request afterwards.
- EXE_FWD_EN: load with dest=5 → es_fwd_valid=1, es_load_block=1. Same with dest=0 → both 0.

Source files
------------

// File: rtl/exe_stage_if.sv
// Decode-to-execute bus.
// Carries the decode valid/allowin handshake and the decoded instruction
// fields that the execute stage latches.
//   master : decode side (drives ds_* fields, reads es_allowin)
//   slave  : execute side (reads ds_* fields, drives es_allowin)
interface exe_stage_if #(
  parameter int ALU_OP_W = 5
);
  logic                ds_to_es_valid;
  logic [31:0]         ds_pc;
  logic [ALU_OP_W-1:0] ds_alu_op;
  logic [31:0]         ds_src1;
  logic [31:0]         ds_src2;
  logic [31:0]         ds_rf_src1;
  logic [31:0]         ds_rf_src2;
  logic [4:0]          ds_dest;
  logic                ds_gr_we;
  logic                ds_mem_we;
  logic                ds_res_from_mem;
  logic [31:0]         ds_st_data;
  logic                es_allowin;

  modport master (
    output ds_to_es_valid, ds_pc, ds_alu_op, ds_src1, ds_src2,
           ds_rf_src1, ds_rf_src2, ds_dest, ds_gr_we, ds_mem_we,
           ds_res_from_mem, ds_st_data,
    input  es_allowin
  );

  modport slave (
    input  ds_to_es_valid, ds_pc, ds_alu_op, ds_src1, ds_src2,
           ds_rf_src1, ds_rf_src2, ds_dest, ds_gr_we, ds_mem_we,
           ds_res_from_mem, ds_st_data,
    output es_allowin
  );
endinterface

// File: rtl/exe_stage.sv
// Execute-stage pipeline register and control.
// Latches the decoded instruction, drives the external combinational ALU
// from the held registers, converts a taken branch into a single flush
// pulse, issues the data-SRAM request and forwards results to memory stage.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   ds                     decode bus (exe_stage_if.slave)
//   exe_pc..alu_op         ALU operand outputs
//   exe_alu_result/br_*    ALU results
//   br_flush, br_target    fetch redirect / decode kill
//   ms_allowin             memory-stage backpressure
//   es_*                   memory-stage payload
//   data_sram_*            data-SRAM request
// Optional macro EXE_FWD_EN adds es_fwd_valid/dest/data and es_load_block.
module exe_stage #(
  parameter logic [31:0] PC_RESET = 32'h1bfffffc,
  parameter int          ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                resetn,
  exe_stage_if.slave          ds,
  output logic [31:0]         exe_pc,
  output logic [31:0]         src1,
  output logic [31:0]         src2,
  output logic [31:0]         alu_rf_src1,
  output logic [31:0]         alu_rf_src2,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         exe_alu_result,
  input  logic                exe_br_taken,
  input  logic [31:0]         exe_br_target,
  output logic                br_flush,
  output logic [31:0]         br_target,
  input  logic                ms_allowin,
  output logic                es_to_ms_valid,
  output logic [31:0]         es_pc,
  output logic [31:0]         es_result,
  output logic [4:0]          es_dest,
  output logic                es_gr_we,
  output logic                es_res_from_mem,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata
`ifdef EXE_FWD_EN
  ,
  output logic                es_fwd_valid,
  output logic [4:0]          es_fwd_dest,
  output logic [31:0]         es_fwd_data,
  output logic                es_load_block
`endif
);

  logic                es_valid;
  logic                br_done;
  logic                es_allowin;
  logic [31:0]         pc_r;
  logic [ALU_OP_W-1:0] alu_op_r;
  logic [31:0]         src1_r;
  logic [31:0]         src2_r;
  logic [31:0]         rf_src1_r;
  logic [31:0]         rf_src2_r;
  logic [4:0]          dest_r;
  logic                gr_we_r;
  logic                mem_we_r;
  logic                res_from_mem_r;
  logic [31:0]         st_data_r;

  // Single-cycle stage: ready-go is always 1.
  assign es_allowin    = !es_valid || ms_allowin;
  assign ds.es_allowin = es_allowin;

  // br_done remembers that a stalled branch already redirected fetch.
  assign br_flush  = es_valid && exe_br_taken && !br_done;
  assign br_target = exe_br_target;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid       <= 1'b0;
      br_done        <= 1'b0;
      pc_r           <= PC_RESET;
      alu_op_r       <= '0;
      src1_r         <= '0;
      src2_r         <= '0;
      rf_src1_r      <= '0;
      rf_src2_r      <= '0;
      dest_r         <= '0;
      gr_we_r        <= 1'b0;
      mem_we_r       <= 1'b0;
      res_from_mem_r <= 1'b0;
      st_data_r      <= '0;
    end else begin
      if (es_allowin) begin
        // A flush leaving this cycle kills the wrong-path instruction arriving.
        es_valid <= ds.ds_to_es_valid && !br_flush;
        br_done  <= 1'b0;
      end else if (br_flush) begin
        br_done  <= 1'b1;
      end
      if (ds.ds_to_es_valid && es_allowin) begin
        pc_r           <= ds.ds_pc;
        alu_op_r       <= ds.ds_alu_op;
        src1_r         <= ds.ds_src1;
        src2_r         <= ds.ds_src2;
        rf_src1_r      <= ds.ds_rf_src1;
        rf_src2_r      <= ds.ds_rf_src2;
        dest_r         <= ds.ds_dest;
        gr_we_r        <= ds.ds_gr_we;
        mem_we_r       <= ds.ds_mem_we;
        res_from_mem_r <= ds.ds_res_from_mem;
        st_data_r      <= ds.ds_st_data;
      end
    end
  end

  assign exe_pc      = pc_r;
  assign alu_op      = alu_op_r;
  assign src1        = src1_r;
  assign src2        = src2_r;
  assign alu_rf_src1 = rf_src1_r;
  assign alu_rf_src2 = rf_src2_r;

  assign es_to_ms_valid  = es_valid;
  assign es_pc           = pc_r;
  assign es_result       = exe_alu_result;
  assign es_dest         = dest_r;
  assign es_gr_we        = gr_we_r;
  assign es_res_from_mem = res_from_mem_r;

  // Request only on the cycle the instruction leaves, so a stall never
  // issues a duplicate access.
  assign data_sram_en    = es_valid && ms_allowin && (mem_we_r || res_from_mem_r);
  assign data_sram_we    = {4{mem_we_r && data_sram_en}};
  assign data_sram_addr  = exe_alu_result;
  assign data_sram_wdata = st_data_r;

`ifdef EXE_FWD_EN
  assign es_fwd_valid  = es_valid && gr_we_r && (dest_r != 5'd0);
  assign es_fwd_dest   = dest_r;
  assign es_fwd_data   = exe_alu_result;
  assign es_load_block = es_fwd_valid && res_from_mem_r;
`endif

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
  localparam logic [31:0] PC_RESET = 32'h1bfffffc;
  localparam int          OPW      = 5;
  localparam logic [4:0]  OP_ADD   = 5'd0;
  localparam logic [4:0]  OP_BEQ   = 5'd11;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ms_allowin = 1'b1;
  logic [31:0] exe_pc, src1, src2, alu_rf_src1, alu_rf_src2;
  logic [4:0]  alu_op;
  logic [31:0] exe_alu_result, exe_br_target;
  logic        exe_br_taken;
  logic        br_flush;
  logic [31:0] br_target;
  logic        es_to_ms_valid;
  logic [31:0] es_pc, es_result;
  logic [4:0]  es_dest;
  logic        es_gr_we, es_res_from_mem;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
`ifdef EXE_FWD_EN
  logic        es_fwd_valid, es_load_block;
  logic [4:0]  es_fwd_dest;
  logic [31:0] es_fwd_data;
`endif

  int n_err = 0;
  int n_chk = 0;

  exe_stage_if #(.ALU_OP_W(OPW)) ds_if ();

  exe_stage #(.PC_RESET(PC_RESET), .ALU_OP_W(OPW)) dut (
    .clk(clk), .resetn(resetn), .ds(ds_if),
    .exe_pc(exe_pc), .src1(src1), .src2(src2),
    .alu_rf_src1(alu_rf_src1), .alu_rf_src2(alu_rf_src2), .alu_op(alu_op),
    .exe_alu_result(exe_alu_result), .exe_br_taken(exe_br_taken),
    .exe_br_target(exe_br_target), .br_flush(br_flush), .br_target(br_target),
    .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc),
    .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
    .es_res_from_mem(es_res_from_mem), .data_sram_en(data_sram_en),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
`ifdef EXE_FWD_EN
    , .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest),
    .es_fwd_data(es_fwd_data), .es_load_block(es_load_block)
`endif
  );

  always #5 clk = ~clk;

  // Toy ALU: result/address is src1+src2, beq compares raw register values,
  // branch target is pc + src2.
  function automatic logic [31:0] f_res(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction
  function automatic logic f_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return (op == OP_BEQ) && (a == b);
  endfunction

  assign exe_alu_result = f_res(src1, src2);
  assign exe_br_taken   = f_taken(alu_op, alu_rf_src1, alu_rf_src2);
  assign exe_br_target  = exe_pc + src2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One slot: the instruction sitting in execute, plus whether its branch
  // has already redirected fetch.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  op;
    logic [31:0] s1, s2, r1, r2;
    logic [4:0]  dest;
    logic        gr_we, mem_we, ld;
    logic [31:0] st;
  } ins_t;

  logic m_valid;
  logic m_redirected;
  ins_t m_ins;

  function automatic ins_t incoming();
    ins_t t;
    t.pc = ds_if.ds_pc; t.op = ds_if.ds_alu_op;
    t.s1 = ds_if.ds_src1; t.s2 = ds_if.ds_src2;
    t.r1 = ds_if.ds_rf_src1; t.r2 = ds_if.ds_rf_src2;
    t.dest = ds_if.ds_dest; t.gr_we = ds_if.ds_gr_we;
    t.mem_we = ds_if.ds_mem_we; t.ld = ds_if.ds_res_from_mem;
    t.st = ds_if.ds_st_data;
    return t;
  endfunction

  function automatic logic m_can_take();
    return !m_valid || ms_allowin;
  endfunction
  function automatic logic m_flush();
    return m_valid && f_taken(m_ins.op, m_ins.r1, m_ins.r2) && !m_redirected;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid = 1'b0;
      m_redirected = 1'b0;
      m_ins = '0;
      m_ins.pc = PC_RESET;
    end else begin
      logic take, fl;
      take = m_can_take();
      fl   = m_flush();
      if (take) begin
        if (ds_if.ds_to_es_valid) m_ins = incoming();
        m_valid = ds_if.ds_to_es_valid && !fl;
        m_redirected = 1'b0;
      end else if (fl) begin
        m_redirected = 1'b1;
      end
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    logic exp_en;
    exp_en = m_valid && ms_allowin && (m_ins.mem_we || m_ins.ld);
    chk("allowin", 32'(ds_if.es_allowin), 32'(m_can_take()));
    chk("to_ms_valid", 32'(es_to_ms_valid), 32'(m_valid));
    chk("br_flush", 32'(br_flush), 32'(m_flush()));
    if (m_flush()) chk("br_target", br_target, m_ins.pc + m_ins.s2);
    chk("exe_pc", exe_pc, m_ins.pc);
    chk("es_pc", es_pc, m_ins.pc);
    chk("alu_op", 32'(alu_op), 32'(m_ins.op));
    chk("src1", src1, m_ins.s1);
    chk("src2", src2, m_ins.s2);
    chk("rf_src1", alu_rf_src1, m_ins.r1);
    chk("rf_src2", alu_rf_src2, m_ins.r2);
    chk("es_result", es_result, f_res(m_ins.s1, m_ins.s2));
    chk("es_dest", 32'(es_dest), 32'(m_ins.dest));
    chk("es_gr_we", 32'(es_gr_we), 32'(m_ins.gr_we));
    chk("es_ld", 32'(es_res_from_mem), 32'(m_ins.ld));
    chk("sram_en", 32'(data_sram_en), 32'(exp_en));
    chk("sram_we", 32'(data_sram_we), (exp_en && m_ins.mem_we) ? 32'hf : 32'h0);
    if (exp_en) chk("sram_addr", data_sram_addr, f_res(m_ins.s1, m_ins.s2));
    chk("sram_wdata", data_sram_wdata, m_ins.st);
`ifdef EXE_FWD_EN
    chk("fwd_valid", 32'(es_fwd_valid), 32'(m_valid && m_ins.gr_we && m_ins.dest != 0));
    chk("load_block", 32'(es_load_block), 32'(m_valid && m_ins.gr_we && m_ins.dest != 0 && m_ins.ld));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] op,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] dest, input logic we, input logic mw,
                       input logic ld, input logic [31:0] st);
    ds_if.ds_to_es_valid = v;  ds_if.ds_pc = pc;  ds_if.ds_alu_op = op;
    ds_if.ds_src1 = s1;  ds_if.ds_src2 = s2;
    ds_if.ds_rf_src1 = r1;  ds_if.ds_rf_src2 = r2;
    ds_if.ds_dest = dest;  ds_if.ds_gr_we = we;  ds_if.ds_mem_we = mw;
    ds_if.ds_res_from_mem = ld;  ds_if.ds_st_data = st;
  endtask

  task automatic idle();
    ds_if.ds_to_es_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held_s1;
    int flushes;
    drive(0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ms_allowin = 1'b1;
    resetn = 1'b0;
    step(); step();
    chk("rst_allowin", 32'(ds_if.es_allowin), 32'h1);
    chk("rst_to_ms", 32'(es_to_ms_valid), 32'h0);
    chk("rst_flush", 32'(br_flush), 32'h0);
    chk("rst_exe_pc", exe_pc, 32'h1bfffffc);
    chk("rst_sram_en", 32'(data_sram_en), 32'h0);
    resetn = 1'b1;
    step();

    // add 3+4
    drive(1, 32'h1c000000, OP_ADD, 3, 4, 0, 0, 5'd2, 1, 0, 0, 0);
    step();
    chk("add_valid", 32'(es_to_ms_valid), 32'h1);
    chk("add_result", es_result, 32'd7);
    idle();
    step();

    // taken beq with a wrong-path instruction arriving behind it
    drive(1, 32'h1c000000, OP_BEQ, 0, 32'h10, 5, 5, 0, 0, 0, 0, 0);
    step();
    chk("beq_flush", 32'(br_flush), 32'h1);
    chk("beq_target", br_target, 32'h1c000010);
    drive(1, 32'h1c000004, OP_ADD, 1, 1, 0, 0, 5'd3, 1, 0, 0, 0);
    step();
    chk("wrong_path_dropped", 32'(es_to_ms_valid), 32'h0);
    chk("no_second_flush", 32'(br_flush), 32'h0);
    idle();
    step();

    // stalled taken branch
    ms_allowin = 1'b0;
    drive(1, 32'h1c000020, OP_BEQ, 32'h55, 32'h8, 9, 9, 0, 0, 0, 0, 0);
    step();
    idle();
    flushes = 0;
    held_s1 = src1;
    chk("stall_first_flush", 32'(br_flush), 32'h1);
    if (br_flush) flushes++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (br_flush) flushes++;
      chk("stall_src1_stable", src1, 32'h55);
      chk("stall_held", 32'(es_to_ms_valid), 32'h1);
    end
    chk("stall_flush_count", 32'(flushes), 32'd1);
    chk("stall_held_s1", held_s1, 32'h55);
    ms_allowin = 1'b1;
    step();
    chk("stall_branch_left", 32'(es_to_ms_valid), 32'h0);

    // store, no stall
    drive(1, 32'h1c000030, OP_ADD, 32'hf0, 32'h10, 0, 0, 0, 0, 1, 0, 32'hdeadbeef);
    step();
    idle();
    chk("st_en", 32'(data_sram_en), 32'h1);
    chk("st_we", 32'(data_sram_we), 32'hf);
    chk("st_addr", data_sram_addr, 32'h100);
    chk("st_wdata", data_sram_wdata, 32'hdeadbeef);
    step();
    chk("st_en_once", 32'(data_sram_en), 32'h0);

    // store behind a stall
    ms_allowin = 1'b0;
    drive(1, 32'h1c000034, OP_ADD, 32'hf0, 32'h10, 0, 0, 0, 0, 1, 0, 32'h12345678);
    step();
    idle();
    chk("st_stall_en0", 32'(data_sram_en), 32'h0);
    step();
    chk("st_stall_en1", 32'(data_sram_en), 32'h0);
    ms_allowin = 1'b1;
    #1;
    chk("st_release_en", 32'(data_sram_en), 32'h1);
    chk("st_release_wdata", data_sram_wdata, 32'h12345678);
    step();
    chk("st_after_en", 32'(data_sram_en), 32'h0);

    // load dest=5, stalled, then async reset between edges
    ms_allowin = 1'b0;
    drive(1, 32'h1c000040, OP_ADD, 32'h200, 32'h4, 0, 0, 5'd5, 1, 0, 1, 0);
    step();
    idle();
`ifdef EXE_FWD_EN
    chk("ld5_fwd_valid", 32'(es_fwd_valid), 32'h1);
    chk("ld5_load_block", 32'(es_load_block), 32'h1);
    chk("ld5_fwd_dest", 32'(es_fwd_dest), 32'd5);
    chk("ld5_fwd_data", es_fwd_data, 32'h204);
`endif
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_to_ms", 32'(es_to_ms_valid), 32'h0);
    chk("arst_allowin", 32'(ds_if.es_allowin), 32'h1);
    chk("arst_exe_pc", exe_pc, 32'h1bfffffc);
    chk("arst_dest", 32'(es_dest), 32'h0);
    ms_allowin = 1'b1;
    #1;
    chk("arst_sram_en", 32'(data_sram_en), 32'h0);
    step();
    chk("arst_sram_en2", 32'(data_sram_en), 32'h0);
    resetn = 1'b1;
    step();

    // load dest=0
    drive(1, 32'h1c000044, OP_ADD, 32'h200, 32'h8, 0, 0, 5'd0, 1, 0, 1, 0);
    step();
    idle();
    chk("ld0_sram_en", 32'(data_sram_en), 32'h1);
`ifdef EXE_FWD_EN
    chk("ld0_fwd_valid", 32'(es_fwd_valid), 32'h0);
    chk("ld0_load_block", 32'(es_load_block), 32'h0);
`endif
    step();

    // back-to-back adds with an intermittent stall, checked by the model
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h1c000100 + 32'(i * 4), OP_ADD, 32'(i), 32'(i * 3), 0, 0,
            5'(i + 1), 1, 0, 0, 0);
      ms_allowin = (i % 3 != 2);
      step();
      if (ms_allowin) chk("b2b_result", es_result, 32'(i * 4));
    end
    idle();
    ms_allowin = 1'b1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
